// File: rtl/display_interface_n.sv
// Seven-segment display front end: sequential binary-to-BCD conversion on a
// load strobe, leading-zero blanking, decimal points, overflow dashes, scanning.
module display_interface_n #(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 16,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BIN_W-1:0]  value,
  input  logic              load,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT     = pow10(DIGITS);
  localparam logic [63:0] MAX_IN    = (64'd1 << BIN_W) - 64'd1;
  localparam bit          OVF_REACH = (MAX_IN >= LIMIT);

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = OFF;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t             state, state_next;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd, bcd_adj, display;
  logic [CNT_W-1:0]   iter;
  logic               blank_hold, ovf_hold, ovf_in, zero_above;
  logic [DIGITS-1:0]  dp_hold, dp_reg, blank, blank_next;
  logic [63:0]        value_ext;
  logic [PRE_W-1:0]   presc;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         cur_nib;

  assign busy      = (state != IDLE);
  assign value_ext = 64'(value);
  assign ovf_in    = OVF_REACH ? (value_ext >= LIMIT) : 1'b0;
  assign cur_nib   = display[4*int'(idx) +: 4];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONV;
      CONV:    if (iter == CNT_W'(1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction ahead of the shift, and the leading-zero mask scanned from the top digit down
  always_comb begin
    bcd_adj    = bcd;
    zero_above = 1'b1;
    blank_next = '0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (bcd[4*i +: 4] == 4'd0);
      blank_next[i] = blank_hold & zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr     <= '0;
      bcd        <= '0;
      iter       <= '0;
      blank_hold <= 1'b0;
      dp_hold    <= '0;
      ovf_hold   <= 1'b0;
      display    <= '0;
      dp_reg     <= '0;
      blank      <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin_sr     <= value;
          bcd        <= '0;
          iter       <= CNT_W'(BIN_W);
          blank_hold <= blank_lz;
          dp_hold    <= dp_mask;
          ovf_hold   <= ovf_in;
        end
        CONV: begin
          bcd    <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
          bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
          iter   <= iter - 1'b1;
        end
        COMMIT: begin
          display <= bcd;
          dp_reg  <= dp_hold;
          blank   <= ovf_hold ? '0 : blank_next;
          ovf     <= ovf_hold;
        end
        default: ;
      endcase
    end
  end

  // Free-running digit scan, independent of conversion activity
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_W'(REFRESH_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= 7'b1000000;
      dp  <= 1'b1;
      an  <= ~DIGITS'(1);
    end else begin
      an <= ~(DIGITS'(1) << idx);
      if (ovf) begin
        seg <= DASH;
        dp  <= 1'b1;
      end else if (blank[idx]) begin
        seg <= OFF;
        dp  <= 1'b1;
      end else begin
        seg <= seg_code(cur_nib);
        dp  <= ~dp_reg[idx];
      end
    end
  end

endmodule

// File: tb/tb_display_interface_n.sv
// Directed self-checking bench for display_interface_n with DIGITS=4,
// BIN_W=16, REFRESH_DIV=4; outputs are sampled on the falling clock edge.
module tb_display_interface_n;

  localparam int DIGITS      = 4;
  localparam int BIN_W       = 16;
  localparam int REFRESH_DIV = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [BIN_W-1:0]  value;
  logic              load;
  logic              blank_lz;
  logic [DIGITS-1:0] dp_mask;
  logic              busy;
  logic              ovf;
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] an;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;

  display_interface_n #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .blank_lz(blank_lz), .dp_mask(dp_mask), .busy(busy), .ovf(ovf),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  // Wait (bounded) until digit i is selected, then check its segments and dp
  task automatic checkDigit(input int i, input logic [6:0] exp_seg, input logic exp_dp, input string tag);
    logic [3:0] target;
    int n;
    target = ~(4'b0001 << i);
    n = 0;
    while (an !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (an !== target) checkOutput({tag, "_an_timeout"}, 32'(an), 32'(target));
    else begin
      checkOutput({tag, "_seg"}, 32'(seg), 32'(exp_seg));
      checkOutput({tag, "_dp"}, 32'(dp), 32'(exp_dp));
    end
  endtask

  task automatic checkDisplay(input string tag, input logic [27:0] segs, input logic [3:0] dps);
    for (int i = 0; i < DIGITS; i++)
      checkDigit(i, segs[7*i +: 7], dps[i], $sformatf("%s_d%0d", tag, i));
  endtask

  // Load a value, check busy over the conversion window, then step to the first fresh output cycle
  task automatic applyStimulus(input logic [15:0] v, input logic blz, input logic [3:0] dpm, input string tag);
    @(negedge clk);
    value = v; blank_lz = blz; dp_mask = dpm; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i <= BIN_W; i++) begin
      checkOutput($sformatf("%s_busy_hi%0d", tag, i), 32'(busy), 32'd1);
      @(negedge clk);
    end
    checkOutput({tag, "_busy_lo"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] prev_an;
    int run_len, changes;
    bit first_run;

    reset = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0; dp_mask = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_an", 32'(an), 32'b1110);
    checkOutput("rst_seg", 32'(seg), 32'(S0));
    checkOutput("rst_dp", 32'(dp), 32'd1);
    reset = 1'b0;

    prev_an = an; run_len = 1; changes = 0; first_run = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_seg", 32'(seg), 32'(S0));
      checkOutput("idle_dp", 32'(dp), 32'd1);
      if (an !== prev_an) begin
        checkOutput("an_order", 32'(an), 32'({prev_an[2:0], prev_an[3]}));
        if (!first_run) checkOutput("an_dwell", 32'(run_len), 32'(REFRESH_DIV));
        first_run = 1'b0;
        run_len = 1;
        changes++;
        prev_an = an;
      end else begin
        run_len++;
      end
    end
    checkOutput("an_changes", 32'(changes), 32'd4);
    checkOutput("idle_ovf", 32'(ovf), 32'd0);

    applyStimulus(16'd1234, 1'b0, 4'b0000, "v1234");
    checkOutput("v1234_ovf", 32'(ovf), 32'd0);
    checkDisplay("v1234", {S1, S2, S3, S4}, 4'b1111);

    applyStimulus(16'd9999, 1'b0, 4'b0000, "v9999");
    checkOutput("v9999_ovf", 32'(ovf), 32'd0);
    checkDisplay("v9999", {S9, S9, S9, S9}, 4'b1111);

    applyStimulus(16'd10000, 1'b0, 4'b1111, "v10000");
    checkOutput("v10000_ovf", 32'(ovf), 32'd1);
    checkDisplay("v10000", {SD, SD, SD, SD}, 4'b1111);

    applyStimulus(16'd7, 1'b1, 4'b0011, "v7blz");
    checkOutput("v7blz_ovf", 32'(ovf), 32'd0);
    checkDisplay("v7blz", {SB, SB, SB, S7}, 4'b1110);

    applyStimulus(16'd0, 1'b1, 4'b0000, "v0blz");
    checkDisplay("v0blz", {SB, SB, SB, S0}, 4'b1111);

    applyStimulus(16'd5086, 1'b0, 4'b0100, "v5086");
    checkDisplay("v5086", {S5, S0, S8, S6}, 4'b1011);

    // A second load during busy must be dropped, not queued
    @(negedge clk);
    value = 16'd1234; blank_lz = 1'b0; dp_mask = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    value = 16'd5678; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checkOutput("ign_busy", 32'(busy), 32'd1);
    begin
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput("ign_done", 32'(busy), 32'd0);
    end
    repeat (3) @(negedge clk);
    checkOutput("ign_noqueue", 32'(busy), 32'd0);
    checkDisplay("ign", {S1, S2, S3, S4}, 4'b1111);

    // Reset part-way through a conversion clears ovf left over from 10000
    applyStimulus(16'd10000, 1'b0, 4'b0000, "pre_rst");
    checkOutput("pre_rst_ovf", 32'(ovf), 32'd1);
    @(negedge clk);
    value = 16'd4321; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
    checkDisplay("abort", {S0, S0, S0, S0}, 4'b1111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
